// File: rtl/core_pkg.sv
// core_pkg: shared register-file constants and write-port arbiter state encoding
package core_pkg;
    localparam int REG_IDX_W = 5;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    typedef enum logic [1:0] {IDLE, WAIT, STARVE} arbState_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write vector for long-latency destinations with three lookup ports
module reg_scoreboard
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 setEn,
    input  logic [REG_IDX_W-1:0] setReg,
    input  logic                 clrEn,
    input  logic [REG_IDX_W-1:0] clrReg,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    output logic                 hitRs1,
    output logic                 hitRs2,
    output logic                 hitRd
);
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] setMask;
    logic [NUM_REGS-1:0] clrMask;
    assign setMask = setEn ? (NUM_REGS'(1) << setReg) : '0;
    assign clrMask = clrEn ? (NUM_REGS'(1) << clrReg) : '0;
    // Set is applied after clear so it wins on a same-edge collision; x0 is masked off.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= ((pending & ~clrMask) | setMask) & ~NUM_REGS'(1);
    end
    assign hitRs1 = pending[rs1];
    assign hitRs2 = pending[rs2];
    assign hitRd  = pending[rd];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between writeback and the
// long-latency unit, tracks outstanding long writes and stalls issue on hazards/starvation
module regfile_wb_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wbValid,
    input  logic [REG_IDX_W-1:0] wbReg,
    input  logic [XLEN-1:0]      wbData,
    input  logic                 luValid,
    output logic                 luReady,
    input  logic [REG_IDX_W-1:0] luReg,
    input  logic [XLEN-1:0]      luData,
    input  logic                 issueValid,
    input  logic                 issueLong,
    input  logic [REG_IDX_W-1:0] issueRs1,
    input  logic [REG_IDX_W-1:0] issueRs2,
    input  logic [REG_IDX_W-1:0] issueRd,
    output logic                 issueStall,
    output logic                 starveStall,
    output logic                 regWriteEnable,
    output logic [REG_IDX_W-1:0] regWriteReg,
    output logic [XLEN-1:0]      regWriteData
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic wbLive, luLive, outFromLu;
    logic hitRs1, hitRs2, hitRd;
    arbState_t state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    assign wbLive      = wbValid && (wbReg != '0);
    assign luLive      = luValid && (luReg != '0);
    assign luReady     = luValid && !wbLive;
    assign starveStall = (state == STARVE);
    assign issueStall  = issueValid && (hitRs1 || hitRs2 || hitRd || starveStall);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regWriteEnable <= 1'b0;
            regWriteReg    <= '0;
            regWriteData   <= '0;
            outFromLu      <= 1'b0;
        end else if (wbLive) begin
            regWriteEnable <= 1'b1;
            regWriteReg    <= wbReg;
            regWriteData   <= wbData;
            outFromLu      <= 1'b0;
        end else if (luReady && luLive) begin
            regWriteEnable <= 1'b1;
            regWriteReg    <= luReg;
            regWriteData   <= luData;
            outFromLu      <= 1'b1;
        end else begin
            regWriteEnable <= 1'b0;
        end
    end
    // Pending bit drops on the same edge the register file commits the long result.
    reg_scoreboard uSb (
        .clk    (clk),
        .rst_n  (rst_n),
        .setEn  (issueValid && issueLong && !issueStall && (issueRd != '0)),
        .setReg (issueRd),
        .clrEn  (regWriteEnable && outFromLu),
        .clrReg (regWriteReg),
        .rs1    (issueRs1),
        .rs2    (issueRs2),
        .rd     (issueRd),
        .hitRs1 (hitRs1),
        .hitRs2 (hitRs2),
        .hitRd  (hitRd)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (!luValid || luReady) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else if (state == IDLE) begin
            cntNext   = CNT_W'(1);
            stateNext = (cntNext >= LIMIT) ? STARVE : WAIT;
        end else if (state == WAIT) begin
            cntNext   = cnt + 1'b1;
            stateNext = (cntNext >= LIMIT) ? STARVE : WAIT;
        end
    end
    // Long-latency result must hold steady until accepted.
    assert property (@(posedge clk) disable iff (!rst_n)
        luValid && !luReady |=> luValid && $stable(luReg) && $stable(luData));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed table, corner sequences and randomized run against a reference model
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wbValid, luValid, luReady, issueValid, issueLong, issueStall, starveStall, regWriteEnable;
    logic [4:0] wbReg, luReg, issueRs1, issueRs2, issueRd, regWriteReg;
    logic [31:0] wbData, luData, regWriteData;
    int passCnt = 0;
    int totalCnt = 0;

    typedef struct {
        bit wbV; bit [4:0] wbR; bit [31:0] wbD;
        bit luV; bit [4:0] luR; bit [31:0] luD;
        bit isV; bit isL; bit [4:0] r1; bit [4:0] r2; bit [4:0] rd;
        bit eReady; bit eStall; bit eEn; bit [4:0] eReg; bit [31:0] eData;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData),
        .luValid(luValid), .luReady(luReady), .luReg(luReg), .luData(luData),
        .issueValid(issueValid), .issueLong(issueLong),
        .issueRs1(issueRs1), .issueRs2(issueRs2), .issueRd(issueRd),
        .issueStall(issueStall), .starveStall(starveStall),
        .regWriteEnable(regWriteEnable), .regWriteReg(regWriteReg), .regWriteData(regWriteData)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic setIn(input bit wbV, input bit [4:0] wbR, input bit [31:0] wbD,
                         input bit luV, input bit [4:0] luR, input bit [31:0] luD,
                         input bit isV, input bit isL, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd);
        wbValid = wbV; wbReg = wbR; wbData = wbD;
        luValid = luV; luReg = luR; luData = luD;
        issueValid = isV; issueLong = isL; issueRs1 = r1; issueRs2 = r2; issueRd = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit wbV, bit [4:0] wbR, bit [31:0] wbD, bit luV, bit [4:0] luR, bit [31:0] luD,
                                bit isV, bit isL, bit [4:0] r1, bit [4:0] r2, bit [4:0] rd,
                                bit eReady, bit eStall, bit eEn, bit [4:0] eReg, bit [31:0] eData);
        vec_t v;
        v.wbV = wbV; v.wbR = wbR; v.wbD = wbD; v.luV = luV; v.luR = luR; v.luD = luD;
        v.isV = isV; v.isL = isL; v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.eReady = eReady; v.eStall = eStall; v.eEn = eEn; v.eReg = eReg; v.eData = eData;
        return v;
    endfunction

    initial begin
        bit mp[32];
        bit mEn, mFromLu, mReady, mStall, luHeld;
        bit [4:0] mReg, hR;
        bit [31:0] mData, hD;
        int mBlk;
        bit wV, lV, iV, iL;
        bit [4:0] wR, r1, r2, rd;
        bit [31:0] wD;

        // conflict, RAW, x0 handling, same-edge set/clear, rs2/rd lookups
        tbl.push_back(mk(1, 3, 'h33, 1, 7, 'h1234, 0, 0, 0, 0, 0,  0, 0, 1, 3, 'h33));
        tbl.push_back(mk(0, 0, 0, 1, 7, 'h1234, 0, 0, 0, 0, 0,     1, 0, 1, 7, 'h1234));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 9,          0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 10,         0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 'h99, 1, 0, 9, 0, 10,      1, 1, 1, 9, 'h99));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 10,         0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 10,         0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 'hDEAD, 1, 1, 0, 0, 0,     1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h1, 1, 12, 'hC0C0, 0, 0, 0, 0, 0,  1, 0, 1, 12, 'hC0C0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 12, 0, 0,         0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 'h44, 0, 0, 0, 0, 0,       1, 0, 1, 4, 'h44));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4,          0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0,          0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 'h55, 1, 0, 4, 0, 0,       1, 1, 1, 4, 'h55));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0,          0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0,          0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 20,         0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 20, 0,         0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 20,         0, 1, 0, 0, 0));

        // reset held with writeback active
        setIn(1, 5, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 3, 0, 4);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk($sformatf("reset%0d.wen", i), regWriteEnable, 0);
            chk($sformatf("reset%0d.wreg", i), regWriteReg, 0);
            chk($sformatf("reset%0d.wdata", i), regWriteData, 0);
            chk($sformatf("reset%0d.starve", i), starveStall, 0);
            chk($sformatf("reset%0d.stall", i), issueStall, 0);
        end
        rst_n = 1'b1;
        setIn(1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("release.wen", regWriteEnable, 1);
        chk("release.wreg", regWriteReg, 5);
        chk("release.wdata", regWriteData, 32'hA5A5A5A5);

        foreach (tbl[i]) begin
            setIn(tbl[i].wbV, tbl[i].wbR, tbl[i].wbD, tbl[i].luV, tbl[i].luR, tbl[i].luD,
                  tbl[i].isV, tbl[i].isL, tbl[i].r1, tbl[i].r2, tbl[i].rd);
            #2;
            chk($sformatf("v%0d.luReady", i), luReady, tbl[i].eReady);
            chk($sformatf("v%0d.issueStall", i), issueStall, tbl[i].eStall);
            tick;
            chk($sformatf("v%0d.wen", i), regWriteEnable, tbl[i].eEn);
            if (tbl[i].eEn) begin
                chk($sformatf("v%0d.wreg", i), regWriteReg, tbl[i].eReg);
                chk($sformatf("v%0d.wdata", i), regWriteData, tbl[i].eData);
            end
            chk($sformatf("v%0d.starve", i), starveStall, 0);
        end

        // starvation: writeback continuous while x8 waits
        for (int k = 0; k < LIMIT + 2; k++) begin
            setIn(1, 1, k, 1, 8, 32'h88, 1, 0, 0, 0, 0);
            #2;
            chk($sformatf("starve%0d.luReady", k), luReady, 0);
            chk($sformatf("starve%0d.issueStall", k), issueStall, k >= LIMIT);
            tick;
            chk($sformatf("starve%0d.starve", k), starveStall, (k + 1) >= LIMIT);
        end
        setIn(0, 0, 0, 1, 8, 32'h88, 1, 0, 0, 0, 0);
        #2;
        chk("starveEnd.luReady", luReady, 1);
        chk("starveEnd.issueStall", issueStall, 1);
        tick;
        chk("starveEnd.starve", starveStall, 0);
        chk("starveEnd.wen", regWriteEnable, 1);
        chk("starveEnd.wreg", regWriteReg, 8);
        chk("starveEnd.wdata", regWriteData, 32'h88);

        // reset mid-operation drops pending bits
        setIn(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6);
        tick;
        setIn(0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0);
        #2;
        chk("midReset.before", issueStall, 1);
        rst_n = 1'b0;
        setIn(1, 5, 32'h5, 0, 0, 0, 1, 0, 6, 20, 0);
        tick;
        chk("midReset.wen", regWriteEnable, 0);
        rst_n = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 1, 0, 6, 20, 0);
        #2;
        chk("midReset.after", issueStall, 0);
        tick;

        // randomized run against reference model, starting from post-reset state
        foreach (mp[i]) mp[i] = 1'b0;
        mEn = 0; mFromLu = 0; mReg = 0; mData = 0; mBlk = 0; luHeld = 0; hR = 0; hD = 0;
        for (int n = 0; n < 3000; n++) begin
            wV = ($urandom_range(99) < 70);
            wR = 5'($urandom_range(7));
            wD = $urandom;
            if (!luHeld) begin
                lV = $urandom_range(1);
                hR = 5'($urandom_range(7));
                hD = $urandom;
            end else lV = 1'b1;
            iV = $urandom_range(1);
            iL = ($urandom_range(2) == 0);
            r1 = 5'($urandom_range(7));
            r2 = 5'($urandom_range(7));
            rd = 5'($urandom_range(7));
            setIn(wV, wR, wD, lV, hR, hD, iV, iL, r1, r2, rd);
            mReady = lV && !(wV && wR != 0);
            mStall = iV && (mp[r1] || mp[r2] || mp[rd] || mBlk >= LIMIT);
            #2;
            chk($sformatf("rnd%0d.luReady", n), luReady, mReady);
            chk($sformatf("rnd%0d.issueStall", n), issueStall, mStall);
            if (mEn && mFromLu) mp[mReg] = 1'b0;
            if (iV && iL && !mStall && rd != 0) mp[rd] = 1'b1;
            if (wV && wR != 0) begin
                mEn = 1; mReg = wR; mData = wD; mFromLu = 0;
            end else if (mReady && hR != 0) begin
                mEn = 1; mReg = hR; mData = hD; mFromLu = 1;
            end else mEn = 0;
            mBlk = (!lV || mReady) ? 0 : mBlk + 1;
            luHeld = lV && !mReady;
            tick;
            chk($sformatf("rnd%0d.wen", n), regWriteEnable, mEn);
            if (mEn) begin
                chk($sformatf("rnd%0d.wreg", n), regWriteReg, mReg);
                chk($sformatf("rnd%0d.wdata", n), regWriteData, mData);
            end
            chk($sformatf("rnd%0d.starve", n), starveStall, mBlk >= LIMIT);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 integer register file (x0 hardwired to zero). The block shares the register file's single write port between two requesters. The first is the in-order pipeline writeback, which is non-stallable and has priority. The second is a long-latency unit (divider/load miss), which uses a valid/ready handshake. The block also tracks destination registers with a long-latency write outstanding and stalls issue on RAW/WAW hazards against them. It sits between writeback/long-latency unit outputs and the register file write port, and feeds a stall to the issue stage.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles of a long-latency request before starveStall asserts (≥1)
- CNT_W, $clog2(STARVE_LIMIT+1): width of wait counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- wbValid  in  1  pipeline writeback write this cycle
- wbReg  in  5  pipeline writeback destination
- wbData  in  32  pipeline writeback data
- luValid  in  1  long-latency result offered
- luReady  out  1  long-latency result accepted this cycle (combinational)
- luReg  in  5  long-latency destination
- luData  in  32  long-latency data
- issueValid  in  1  instruction present in issue stage
- issueLong  in  1  issuing instruction writes via long-latency unit
- issueRs1, issueRs2, issueRd  in  5 each  issuing instruction register indices
- issueStall  out  1  hold issue stage (combinational)
- starveStall  out  1  long-latency requester starved; pipeline must stop issuing (registered)
- regWriteEnable  out  1  register file write enable (registered)
- regWriteReg  out  5  register file write address (registered)
- regWriteData  out  32  register file write data (registered)

## Operation
- wbLive = wbValid && wbReg!=0; luLive = luValid && luReg!=0 (luValid with luReg==0 is accepted and discarded).
- luReady = luValid && !wbLive. Pipeline writeback always wins. A long-latency result is accepted in any cycle where writeback is idle or targets x0.
- Output stage: on the edge, if wbLive the output stage loads wbReg/wbData with outFromLu=0. Else if luValid&&luReady&&luLive, it loads luReg/luData with outFromLu=1. Else regWriteEnable←0.
- Scoreboard: 32-bit pending vector. Bit 0 is never set.
  - Set on the edge where issueValid && issueLong && !issueStall && issueRd!=0.
  - Clear bit regWriteReg on the edge where regWriteEnable && outFromLu, which is the same edge the register file commits.
  - If set and clear hit the same bit on the same edge, set wins.
- issueStall = issueValid && (pending[issueRs1] || pending[issueRs2] || pending[issueRd] || starveStall). Index 0 never stalls.
- Starvation FSM:
  - IDLE: luValid && !luReady → WAIT, cnt←1.
  - WAIT: on accept → IDLE, cnt←0. Else cnt++; if cnt reaches STARVE_LIMIT → STARVE.
  - STARVE: starveStall=1. On accept → IDLE, cnt←0.
  - luValid dropping without accept (not permitted by protocol) → IDLE.
- Protocol: once luValid is asserted, luReg/luData stay stable until accepted.

## Timing
- Reset values: regWriteEnable=0, regWriteReg=0, regWriteData=0, starveStall=0, pending=0, FSM=IDLE, cnt=0, outFromLu=0. luReady and issueStall follow from their inputs.
- Accept at edge T → regWriteEnable high during cycle T+1. The register file commits at the end of T+1. The pending bit clears at the same edge, so a dependent instruction issues no earlier than T+2.
- starveStall asserts the cycle after cnt reaches STARVE_LIMIT and deasserts the cycle after accept.
- Reset mid-operation: all pending bits drop. The long-latency unit is reset by the same rst_n.

## Structure
- Shared package core_pkg holds REG_IDX_W=5, XLEN=32, NUM_REGS=32 and the arbiter FSM state enum (IDLE, WAIT, STARVE).
- One sub-module is natural: reg_scoreboard, which contains the pending vector, set/clear logic and the three lookup ports. Arbitration, the output register and the FSM stay in the top module.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with wbValid=1 → regWriteEnable=0, pending=0, starveStall=0. Release with wbValid=1, wbReg=5, wbData=0xA5A5A5A5 → next cycle regWriteEnable=1, regWriteReg=5, regWriteData=0xA5A5A5A5.
- Conflict: wbValid (x3) and luValid (x7, 0x1234) in the same cycle → luReady=0. The x3 write comes out first. The cycle after wbValid drops, luReady=1, and the x7 write appears one cycle later.
- Scoreboard RAW: issue long op with rd=x9, then next instruction with rs1=x9 → issueStall=1. Then luValid x9 is accepted at edge T → issueStall stays 1 through T+1 and is 0 in T+2.
- Starvation with STARVE_LIMIT=4: luValid held and wbValid continuous → starveStall=1 after 4 blocked cycles. Drop wbValid → accept occurs, and starveStall=0 the following cycle.
- x0 handling: luValid with luReg=0 → luReady=1 and regWriteEnable stays 0. Long issue with rd=0 → no pending bit set and no stall. wbValid with wbReg=0 → does not block a simultaneous luValid.
- Same-edge set/clear: an x4 long-latency commit (clear) and a long issue to x4 on the same edge → pending[4]=1 afterward.
